// File: rtl/traffic_light_fsm_pkg.sv
// Shared definitions for the two-road traffic-light controller:
// state encodings, lamp bit positions and the duration-counter width.
package traffic_light_fsm_pkg;

    localparam int CNT_W = 8;

    localparam int RED = 2;
    localparam int YEL = 1;
    localparam int GRN = 0;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    // One-hot {red,yellow,green} for a road whose green/yellow states are given.
    function automatic logic [2:0] road_lights(input state_t s,
                                               input state_t grn_st,
                                               input state_t yel_st);
        logic [2:0] l;
        l = '0;
        if (s == grn_st)
            l[GRN] = 1'b1;
        else if (s == yel_st)
            l[YEL] = 1'b1;
        else
            l[RED] = 1'b1;
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Board-side signal bundle of the traffic-light controller: divider and
// button inputs, lamp and status outputs.
interface traffic_light_fsm_if;

    logic       slow_clk;
    logic       ped_btn_n;
    logic [2:0] ns_lights;
    logic [2:0] ew_lights;
    logic       walk;
    logic       ped_pending;
    logic [2:0] state_dbg;

    modport master (
        output slow_clk, ped_btn_n,
        input  ns_lights, ew_lights, walk, ped_pending, state_dbg
    );

    modport slave (
        input  slow_clk, ped_btn_n,
        output ns_lights, ew_lights, walk, ped_pending, state_dbg
    );

endinterface

// File: rtl/traffic_light_fsm_sync_edge_detect.sv
// Two-flop synchronizer followed by an edge register; flags single-cycle
// rising and falling edges of an asynchronous input.
module sync_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s1, s2, prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= RESET_VAL;
            s2   <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road traffic-light controller with pedestrian request, timed by ticks
// derived from the 10 Hz divider output sampled on the board clock.
module traffic_light_fsm
    import traffic_light_fsm_pkg::*;
#(
    parameter int GREEN_TICKS  = 50,
    parameter int SHORT_TICKS  = 10,
    parameter int YELLOW_TICKS = 20,
    parameter int ALLRED_TICKS = 10,
    parameter int WALK_TICKS   = 40
) (
    input logic                clkin,
    input logic                rst,
    traffic_light_fsm_if.slave tl
);

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] SHORT_LD  = CNT_W'(SHORT_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);

    logic tick, press;
    logic slow_fall_unused, btn_rise_unused;

    sync_edge_detect #(.RESET_VAL(1'b0)) u_slow_sync (
        .clk  (clkin),
        .rst  (rst),
        .d    (tl.slow_clk),
        .rise (tick),
        .fall (slow_fall_unused)
    );

    sync_edge_detect #(.RESET_VAL(1'b1)) u_btn_sync (
        .clk  (clkin),
        .rst  (rst),
        .d    (tl.ped_btn_n),
        .rise (btn_rise_unused),
        .fall (press)
    );

    state_t           state, state_n, succ;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pend_q, pend_n;
    logic             legal;

    function automatic logic [CNT_W-1:0] load_for(input state_t s);
        logic [CNT_W-1:0] v;
        case (s)
            NS_GREEN, EW_GREEN:   v = GREEN_LD;
            NS_YELLOW, EW_YELLOW: v = YELLOW_LD;
            ALLRED_A, ALLRED_B:   v = ALLRED_LD;
            PED_WALK:             v = WALK_LD;
            default:              v = GREEN_LD;
        endcase
        return v;
    endfunction

    always_ff @(posedge clkin) begin
        if (rst) begin
            state  <= NS_GREEN;
            cnt    <= GREEN_LD;
            pend_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pend_q <= pend_n;
        end
    end

    always_comb begin
        succ  = NS_GREEN;
        legal = 1'b1;
        case (state)
            NS_GREEN:  succ = NS_YELLOW;
            NS_YELLOW: succ = ALLRED_A;
            ALLRED_A:  succ = EW_GREEN;
            EW_GREEN:  succ = EW_YELLOW;
            EW_YELLOW: succ = ALLRED_B;
            ALLRED_B:  succ = pend_q ? PED_WALK : NS_GREEN;
            PED_WALK:  succ = NS_GREEN;
            default:   legal = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend_q | press;
        if (!legal) begin
            state_n = NS_GREEN;
            cnt_n   = GREEN_LD;
        end else if (tick) begin
            if (cnt == '0) begin
                state_n = succ;
                cnt_n   = load_for(succ);
            end else if ((state == NS_GREEN || state == EW_GREEN) &&
                         pend_q && (cnt > SHORT_LD)) begin
                cnt_n = SHORT_LD;
            end else begin
                cnt_n = cnt - 1'b1;
            end
        end
        // Entering the walk phase serves the request; a press on that very
        // cycle survives the clear and is served on the next round.
        if (state_n == PED_WALK && state != PED_WALK)
            pend_n = press;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            tl.ns_lights <= road_lights(NS_GREEN, NS_GREEN, NS_YELLOW);
            tl.ew_lights <= road_lights(NS_GREEN, EW_GREEN, EW_YELLOW);
            tl.walk      <= 1'b0;
        end else begin
            tl.ns_lights <= road_lights(state, NS_GREEN, NS_YELLOW);
            tl.ew_lights <= road_lights(state, EW_GREEN, EW_YELLOW);
            tl.walk      <= (state == PED_WALK);
        end
    end

    assign tl.ped_pending = pend_q;
    assign tl.state_dbg   = state;

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Downstream consumer of the 12 MHz→10 Hz clock divider: a two-road traffic-light controller with a pedestrian button, for the MAX1000 LEDs.
- Runs entirely on the 12 MHz board clock, with the divider's 10 Hz square wave as data. Each rising edge of that wave becomes a one-cycle tick (100 ms time base).
- All phase durations are counted in ticks.

Parameters:
- GREEN_TICKS, 50, full green duration per road (5.0 s); legal 1..256.
- SHORT_TICKS, 10, green remaining once a pedestrian request is pending (1.0 s); legal 1..GREEN_TICKS.
- YELLOW_TICKS, 20, yellow duration (2.0 s); legal 1..256.
- ALLRED_TICKS, 10, all-red clearance (1.0 s); legal 1..256.
- WALK_TICKS, 40, pedestrian walk phase (4.0 s); legal 1..256.

Ports:
- clkin, in, 1, 12 MHz board clock; sole clock.
- rst, in, 1, synchronous active-high reset.
- slow_clk, in, 1, 10 Hz square wave from the clock divider; asynchronous to the FSM, treated as data.
- ped_btn_n, in, 1, raw user button, active low, asynchronous.
- ns_lights, out, 3, north-south {red,yellow,green}, one-hot.
- ew_lights, out, 3, east-west {red,yellow,green}, one-hot.
- walk, out, 1, pedestrian walk lamp.
- ped_pending, out, 1, request latched and not yet served.
- state_dbg, out, 3, current state encoding.

Behaviour:
- One clock, clkin; reset is synchronous and active-high on rst. All registers update only on the clkin rising edge.
- Synchronizers: slow_clk and ped_btn_n each pass through 2 flip-flops.
  - Reset values: slow_clk chain and its edge register reset to 0; button chain and its edge register reset to 1.
- Tick: tick = synced slow_clk high AND previous sample low. It is one clkin cycle wide and occurs 3 clkin cycles after the slow_clk rise.
  - A slow_clk already high when reset releases yields one tick; this is accepted.
- Press detect: press = synced button low AND previous sample high. Bounce is tolerated because extra presses only re-set an already-set latch.
- States and encoding: NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, PED_WALK=6. Encoding 7 is illegal and goes to NS_GREEN on the next cycle.
- Duration counter: 8-bit down counter, loaded with DURATION-1 on state entry. It decrements on each tick while nonzero. A tick while the count is 0 causes the transition, so each state lasts exactly DURATION ticks.
- Transitions (on tick with count 0):
  - NS_GREEN→NS_YELLOW→ALLRED_A→EW_GREEN→EW_YELLOW→ALLRED_B.
  - ALLRED_B→PED_WALK if ped_pending, else →NS_GREEN.
  - PED_WALK→NS_GREEN.
- Green truncation: in NS_GREEN or EW_GREEN, on a tick with ped_pending=1 and count > SHORT_TICKS-1, the counter loads SHORT_TICKS-1 instead of decrementing. It never lengthens green.
- Pedestrian latch:
  - Set on press.
  - Cleared on the cycle PED_WALK is entered.
  - A press on that same cycle wins (latch stays set) and is served next cycle round.
  - Presses during PED_WALK set the latch for the next cycle round.
- Lights (registered, updated the cycle after the state change):
  - NS green only in NS_GREEN; NS yellow only in NS_YELLOW; otherwise NS red.
  - EW green only in EW_GREEN; EW yellow only in EW_YELLOW; otherwise EW red.
  - walk=1 only in PED_WALK.
- Reset values:
  - state NS_GREEN, counter GREEN_TICKS-1.
  - ns_lights=001, ew_lights=100, walk=0, ped_pending=0, state_dbg=0.
- Reset mid-phase: restarts at NS_GREEN with a full count; the pending request is discarded.
- Invariant: never both roads non-red simultaneously; walk=1 implies both red.

Decomposition:
- Shared package: state encodings, light bit positions (RED=2, YEL=1, GRN=0), counter width constant 8.
- Natural sub-module: sync_edge_detect (2-FF synchronizer plus edge register, reset-value parameter, rise/fall outputs). It is instantiated twice: once for slow_clk and once for ped_btn_n.

Test Plan:
Bench setup: slow_clk driven with a 20-cycle period, GREEN=5, SHORT=2, YELLOW=3, ALLRED=2, WALK=4.
1. Reset, no button -> ns 001/ew 100 for exactly 5 ticks. Then NS_YELLOW for 3 ticks, ALLRED_A for 2, EW_GREEN for 5, EW_YELLOW for 3, ALLRED_B for 2, back to NS_GREEN. walk stays 0 throughout.
2. Tick latency: slow_clk rise at cycle N -> counter change at N+3; lights change at N+4 on the terminal tick.
3. Button pulse low for 5 cycles at the 1st tick of NS_GREEN -> ped_pending=1. NS_GREEN lasts 3 ticks total. Later, after ALLRED_B, PED_WALK runs for 4 ticks with walk=1, both red, ped_pending=0.
4. Bouncing button (4 pulses within 10 cycles) -> single latch; exactly one PED_WALK.
5. rst asserted for 1 cycle during EW_YELLOW with ped_pending=1 -> next cycle NS_GREEN, full 5-tick count, ped_pending=0, no walk.
6. Continuous assertion across all runs -> ns and ew never both non-red; walk=1 only when both equal 100.
